// File: rtl/mio_if.sv
// CPU data-port bus between the single-cycle CPU (master) and the memory/IO controller (slave).
interface mio_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        mio_ready;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, mio_ready
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, mio_ready
    );
endinterface

// File: rtl/mio_bus.sv
// Data-side bus controller: routes CPU accesses to a wait-stated RAM or to LED/SW/timer registers.
// Optional compare timer is built only when MIO_TIMER_EN is defined.
module mio_bus #(
    parameter int RAM_AW   = 10,
    parameter int RAM_WAIT = 1,
    parameter int LED_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    mio_if.slave              bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    input  logic [LED_W-1:0]  sw_in,
    output logic [LED_W-1:0]  led_out,
    output logic              timer_irq
);
    typedef enum logic [1:0] {IDLE, RAMW, DONE} state_t;

    localparam logic [29:0] LED_WA  = 30'h3800_0000;
    localparam logic [29:0] SW_WA   = 30'h3800_0001;
    localparam logic [29:0] TCMP_WA = 30'h3800_0002;
    localparam logic [29:0] TCNT_WA = 30'h3800_0003;

    state_t            state_reg, state_next;
    logic [31:0]       rdata_reg, rdata_next;
    logic [RAM_AW-1:0] ram_addr_reg, ram_addr_next;
    logic [31:0]       ram_wdata_reg, ram_wdata_next;
    logic              ram_we_reg, ram_we_next;
    logic              wr_reg, wr_next;
    logic [3:0]        wcnt_reg, wcnt_next;
    logic [LED_W-1:0]  led_reg, led_next;

    logic [29:0] word_addr;
    logic        is_ram;
    logic        io_wr;
    logic [31:0] io_rdata;
    logic [31:0] tcmp_val;
    logic [31:0] tcount_val;
    logic        unused_addr_lsb;

    assign word_addr       = bus.cpu_addr[31:2];
    assign is_ram          = ~bus.cpu_addr[31];
    assign io_wr           = (state_reg == IDLE) && bus.cpu_req && !is_ram && bus.cpu_we;
    assign unused_addr_lsb = ^bus.cpu_addr[1:0];

`ifdef MIO_TIMER_EN
    logic [31:0] tcount_reg;
    logic [31:0] tcmp_reg;
    logic        irq_reg;

    // A TCOUNT write takes priority over a compare match landing on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcount_reg <= '0;
            tcmp_reg   <= '0;
            irq_reg    <= 1'b0;
        end else begin
            if (io_wr && word_addr == TCNT_WA) begin
                tcount_reg <= '0;
                irq_reg    <= 1'b0;
            end else if (tcmp_reg != '0 && tcount_reg == tcmp_reg) begin
                tcount_reg <= '0;
                irq_reg    <= 1'b1;
            end else begin
                tcount_reg <= tcount_reg + 32'd1;
            end
            if (io_wr && word_addr == TCMP_WA) begin
                tcmp_reg <= bus.cpu_wdata;
            end
        end
    end

    assign tcmp_val   = tcmp_reg;
    assign tcount_val = tcount_reg;
    assign timer_irq  = irq_reg;
`else
    assign tcmp_val   = '0;
    assign tcount_val = '0;
    assign timer_irq  = 1'b0;
`endif

    always_comb begin
        io_rdata = '0;
        case (word_addr)
            LED_WA:  io_rdata = 32'(led_reg);
            SW_WA:   io_rdata = 32'(sw_in);
            TCMP_WA: io_rdata = tcmp_val;
            TCNT_WA: io_rdata = tcount_val;
            default: io_rdata = '0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        rdata_next     = rdata_reg;
        ram_addr_next  = ram_addr_reg;
        ram_wdata_next = ram_wdata_reg;
        ram_we_next    = ram_we_reg;
        wr_next        = wr_reg;
        wcnt_next      = wcnt_reg;
        led_next       = led_reg;
        case (state_reg)
            IDLE: begin
                if (bus.cpu_req) begin
                    if (is_ram) begin
                        ram_addr_next  = bus.cpu_addr[RAM_AW+1:2];
                        ram_wdata_next = bus.cpu_wdata;
                        ram_we_next    = bus.cpu_we;
                        wr_next        = bus.cpu_we;
                        wcnt_next      = 4'(RAM_WAIT);
                        state_next     = RAMW;
                    end else begin
                        if (bus.cpu_we && word_addr == LED_WA) begin
                            led_next = bus.cpu_wdata[LED_W-1:0];
                        end
                        rdata_next = bus.cpu_we ? 32'd0 : io_rdata;
                        state_next = DONE;
                    end
                end
            end
            RAMW: begin
                // Strobe lasts only the first RAMW cycle; wr_reg remembers the direction.
                ram_we_next = 1'b0;
                if (wcnt_reg != 4'd0) begin
                    wcnt_next = wcnt_reg - 4'd1;
                end else begin
                    rdata_next = wr_reg ? 32'd0 : ram_rdata;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            rdata_reg     <= '0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            ram_we_reg    <= 1'b0;
            wr_reg        <= 1'b0;
            wcnt_reg      <= '0;
            led_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            rdata_reg     <= rdata_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
            ram_we_reg    <= ram_we_next;
            wr_reg        <= wr_next;
            wcnt_reg      <= wcnt_next;
            led_reg       <= led_next;
        end
    end

    assign bus.cpu_rdata = rdata_reg;
    assign bus.mio_ready = (state_reg == DONE);
    assign ram_addr      = ram_addr_reg;
    assign ram_wdata     = ram_wdata_reg;
    assign ram_we        = ram_we_reg;
    assign led_out       = led_reg;
endmodule

// File: tb/tb_mio_bus.sv
// Self-checking bench for mio_bus: directed reset/IO/RAM/unmapped/timer/abort steps plus
// randomized accesses scored against a transaction-level model of the address map.
module tb_mio_bus;
    localparam int RAM_AW   = 6;
    localparam int RAM_WAIT = 2;
    localparam int LED_W    = 16;
    localparam int DEPTH    = 1 << RAM_AW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mio_if bus ();
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_we;
    logic [LED_W-1:0]  sw_in;
    logic [LED_W-1:0]  led_out;
    logic              timer_irq;

    mio_bus #(.RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT), .LED_W(LED_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    // External RAM: read data appears RAM_WAIT (=2) cycles after the address.
    logic [31:0] ram_dev [DEPTH];
    logic [31:0] rpipe1 = '0;
    logic [31:0] rpipe2 = '0;
    always @(posedge clk) begin
        if (ram_we === 1'b1) ram_dev[ram_addr] <= ram_wdata;
        rpipe1 <= ram_dev[ram_addr];
        rpipe2 <= rpipe1;
    end
    assign ram_rdata = rpipe2;

    int we_cycles = 0;
    always @(negedge clk) if (ram_we === 1'b1) we_cycles++;

    // Reference model: expected RAM contents and LED register.
    logic [31:0]      exp_mem [int];
    logic [LED_W-1:0] led_exp = '0;

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] model_ram(int i);
        if (exp_mem.exists(i)) return exp_mem[i];
        return init_word(i);
    endfunction

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        @(negedge clk);
        chk("ready_low_before_req", 32'(bus.mio_ready), 32'd0);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        @(posedge clk);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.mio_ready === 1'b1) break;
        end
        rd = bus.cpu_rdata;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'($urandom);
        bus.cpu_addr  = $urandom;
        bus.cpu_wdata = $urandom;
        $display("txn we=%0b addr=%h wdata=%h rdata=%h lat=%0d", we, addr, wd, rd, lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr, wd, rd, exp_rd;
        logic        we, check_rd;
        int          lat, exp_lat, kind, idx, we0, ready_seen;
        logic [LED_W-1:0] led0;

        for (int i = 0; i < DEPTH; i++) ram_dev[i] = init_word(i);

        // 1: reset held low with random inputs
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'hE000_0000;
        bus.cpu_wdata = $urandom;
        sw_in         = LED_W'($urandom);
        repeat (4) begin
            @(negedge clk);
            bus.cpu_req   = 1'($urandom);
            bus.cpu_we    = 1'($urandom);
            bus.cpu_addr  = $urandom;
            bus.cpu_wdata = $urandom;
        end
        @(negedge clk);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_mio_ready", 32'(bus.mio_ready), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_led_out", 32'(led_out), 32'd0);
        chk("rst_timer_irq", 32'(timer_irq), 32'd0);
        bus.cpu_req = 1'b0;
        reset = 1'b1;
        ready_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.mio_ready !== 1'b0) ready_seen++;
        end
        chk("post_rst_no_ready", 32'(ready_seen), 32'd0);

        // 2: IO path
        access(1'b1, 32'hE000_0000, 32'h0000_1234, rd, lat);
        led_exp = 16'h1234;
        chk("led_write_lat", 32'(lat), 32'd1);
        chk("led_out", 32'(led_out), 32'h1234);
        sw_in = 16'hA5A5;
        access(1'b0, 32'hE000_0004, 32'h0, rd, lat);
        chk("sw_read_lat", 32'(lat), 32'd1);
        chk("sw_read_data", rd, 32'h0000_A5A5);
        access(1'b0, 32'hE000_0000, 32'h0, rd, lat);
        chk("led_read_data", rd, 32'h0000_1234);

        // 3: RAM path
        we0 = we_cycles;
        access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, lat);
        exp_mem[4] = 32'hDEAD_BEEF;
        chk("ram_write_lat", 32'(lat), 32'(RAM_WAIT + 2));
        chk("ram_write_addr", 32'(ram_addr), 32'd4);
        chk("ram_we_one_cycle", 32'(we_cycles - we0), 32'd1);
        chk("ram_write_rdata_zero", rd, 32'd0);
        access(1'b0, 32'h0000_0010, 32'h0, rd, lat);
        chk("ram_read_lat", 32'(lat), 32'(RAM_WAIT + 2));
        chk("ram_readback", rd, 32'hDEAD_BEEF);

        // 4: unmapped
        access(1'b0, 32'hF000_0000, 32'h0, rd, lat);
        chk("unmapped_read_lat", 32'(lat), 32'd1);
        chk("unmapped_read_data", rd, 32'd0);
        we0 = we_cycles;
        led0 = led_out;
        access(1'b1, 32'hF000_0000, $urandom, rd, lat);
        chk("unmapped_write_lat", 32'(lat), 32'd1);
        chk("unmapped_write_led", 32'(led_out), 32'(led0));
        chk("unmapped_write_no_ram", 32'(we_cycles - we0), 32'd0);

        // 5: timer
`ifdef MIO_TIMER_EN
        access(1'b1, 32'hE000_0008, 32'd5, rd, lat);
        access(1'b1, 32'hE000_000C, 32'd0, rd, lat);
        chk("tcount_clear_irq", 32'(timer_irq), 32'd0);
        repeat (10) @(negedge clk);
        chk("timer_irq_rise", 32'(timer_irq), 32'd1);
        access(1'b0, 32'hE000_000C, 32'h0, rd, lat);
        chk("tcount_wrapped_read", rd, 32'd5);
        access(1'b1, 32'hE000_000C, 32'd0, rd, lat);
        chk("tcount_write_clears_irq", 32'(timer_irq), 32'd0);
        repeat (4) @(negedge clk);
        access(1'b1, 32'hE000_000C, 32'd0, rd, lat);
        chk("match_cycle_write_wins", 32'(timer_irq), 32'd0);
        access(1'b0, 32'hE000_000C, 32'h0, rd, lat);
        chk("tcount_after_clear", rd, 32'd1);
        access(1'b1, 32'hE000_0008, 32'd0, rd, lat);
        access(1'b1, 32'hE000_000C, 32'd0, rd, lat);
`else
        access(1'b1, 32'hE000_0008, 32'd5, rd, lat);
        access(1'b0, 32'hE000_0008, 32'h0, rd, lat);
        chk("tcmp_reads_zero", rd, 32'd0);
        repeat (20) @(negedge clk);
        chk("no_timer_irq", 32'(timer_irq), 32'd0);
        access(1'b0, 32'hE000_000C, 32'h0, rd, lat);
        chk("tcount_reads_zero", rd, 32'd0);
`endif

        // 6a: reset during RAMW abandons the access
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h0000_0020;
        bus.cpu_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        chk("abort_we_high_in_ramw", 32'(ram_we), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_we_cleared", 32'(ram_we), 32'd0);
        bus.cpu_req = 1'b0;
        ready_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.mio_ready !== 1'b0) ready_seen++;
        end
        chk("abort_no_ready", 32'(ready_seen), 32'd0);
        led_exp = '0;
        chk("abort_led_reset", 32'(led_out), 32'd0);
        reset = 1'b1;

        // 6b: cpu_req dropped during RAMW still completes
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h0000_0024;
        bus.cpu_wdata = 32'h1357_9BDF;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        lat = 1;
        while (lat < 40 && bus.mio_ready !== 1'b1) begin
            @(negedge clk);
            lat++;
        end
        exp_mem[9] = 32'h1357_9BDF;
        chk("drop_req_ready_lat", 32'(lat), 32'(RAM_WAIT + 2));
        access(1'b0, 32'h0000_0024, 32'h0, rd, lat);
        chk("drop_req_committed", rd, 32'h1357_9BDF);
        access(1'b0, 32'h0000_0020, 32'h0, rd, lat);
        chk("abort_not_committed", rd, model_ram(8));

        // Randomized accesses against the model
        for (int t = 0; t < 40; t++) begin
            kind  = $urandom_range(0, 5);
            we    = 1'($urandom);
            wd    = $urandom;
            sw_in = LED_W'($urandom);
            case (kind)
                0, 1:    addr = $urandom & 32'h7FFF_FFFF;
                2:       addr = 32'hE000_0000 | 32'($urandom_range(0, 3));
                3:       addr = 32'hE000_0004 | 32'($urandom_range(0, 3));
`ifdef MIO_TIMER_EN
                4:       addr = 32'hE000_0000;
`else
                4:       addr = 32'hE000_0008 + 32'($urandom_range(0, 1) * 4);
`endif
                default: addr = ($urandom_range(0, 1) == 1) ? (32'h8000_0000 | ($urandom & 32'h1FFF_FFFF))
                                                            : 32'hE000_0010;
            endcase
            check_rd = 1'b1;
            exp_rd   = 32'd0;
            if (addr[31] == 1'b0) begin
                idx     = int'((addr >> 2) % DEPTH);
                exp_lat = RAM_WAIT + 2;
                if (we) exp_mem[idx] = wd;
                else    exp_rd = model_ram(idx);
            end else begin
                exp_lat = 1;
                if (we) begin
                    check_rd = 1'b0;
                    if ((addr & 32'hFFFF_FFFC) == 32'hE000_0000) led_exp = wd[LED_W-1:0];
                end else begin
                    case (addr & 32'hFFFF_FFFC)
                        32'hE000_0000: exp_rd = 32'(led_exp);
                        32'hE000_0004: exp_rd = 32'(sw_in);
                        default:       exp_rd = 32'd0;
                    endcase
                end
            end
            access(we, addr, wd, rd, lat);
            chk("rand_lat", 32'(lat), 32'(exp_lat));
            if (check_rd) chk("rand_rdata", rd, exp_rd);
            chk("rand_led", 32'(led_out), 32'(led_exp));
            if (addr[31] == 1'b0) chk("rand_ram_addr", 32'(ram_addr), 32'((addr >> 2) % DEPTH));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
